// File: rtl/mem_access_unit.sv
// Load/store unit: launches one SRAM-like bus transaction per EX memory op and returns extended load data.
// Build option MEM_ADDR_EXC_EN: misaligned accesses raise adel/ades instead of being force-aligned.
module mem_access_unit #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] bus_addr,
    output logic [3:0]  wstrb,
    output logic [31:0] bus_wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata,
    output logic [31:0] result,
    output logic        done,
    output logic        mem_stall,
    output logic        adel,
    output logic        ades,
    output logic        bus_err
);

    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_DONE} state_t;

    state_t                 r_state, w_next;
    logic [7:0]             r_op;
    logic                   r_wr;
    logic [1:0]             r_size;
    logic [31:0]            r_bus_addr;
    logic [3:0]             r_wstrb;
    logic [31:0]            r_bus_wdata;
    logic [31:0]            r_result;
    logic                   r_bus_err;
    logic [TIMEOUT_W-1:0]   r_wdog;

    logic        w_is_load, w_is_store, w_is_mem;
    logic [1:0]  w_size;
    logic [31:0] w_addr_al;
    logic [3:0]  w_wstrb;
    logic [31:0] w_lane;
    logic        w_try, w_addr_err, w_launch;
    logic        w_in_wait, w_wd_exp, w_capture;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_size     = 2'd0;
        case (op)
            OP_LB, OP_LBU: begin w_is_load  = 1'b1; w_size = 2'd0; end
            OP_LH, OP_LHU: begin w_is_load  = 1'b1; w_size = 2'd1; end
            OP_LW:         begin w_is_load  = 1'b1; w_size = 2'd2; end
            OP_SB:         begin w_is_store = 1'b1; w_size = 2'd0; end
            OP_SH:         begin w_is_store = 1'b1; w_size = 2'd1; end
            OP_SW:         begin w_is_store = 1'b1; w_size = 2'd2; end
            default:       ;
        endcase
    end

    assign w_is_mem = w_is_load | w_is_store;
    assign w_try    = (r_state == S_IDLE) && in_valid && !flush;

`ifdef MEM_ADDR_EXC_EN
    logic w_misalign;
    logic r_adel, r_ades;
    assign w_misalign = ((w_size == 2'd1) && addr[0]) || ((w_size == 2'd2) && (addr[1:0] != 2'b00));
    assign w_addr_err = w_misalign;
    assign w_addr_al  = addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_adel <= 1'b0;
            r_ades <= 1'b0;
        end else begin
            r_adel <= w_try && w_is_load && w_misalign;
            r_ades <= w_try && w_is_store && w_misalign;
        end
    end
    assign adel = r_adel;
    assign ades = r_ades;
`else
    // Misaligned halves/words silently drop the offending low address bits.
    assign w_addr_err = 1'b0;
    assign w_addr_al  = {addr[31:2], addr[1] & (w_size != 2'd2), addr[0] & (w_size == 2'd0)};
    assign adel = 1'b0;
    assign ades = 1'b0;
`endif

    assign w_launch = w_try && w_is_mem && !w_addr_err;

    always_comb begin
        w_wstrb = 4'b0000;
        w_lane  = 32'h0;
        case (op)
            OP_SB: begin w_wstrb = 4'b0001 << w_addr_al[1:0]; w_lane = {4{wdata[7:0]}}; end
            OP_SH: begin w_wstrb = w_addr_al[1] ? 4'b1100 : 4'b0011; w_lane = {2{wdata[15:0]}}; end
            OP_SW: begin w_wstrb = 4'b1111; w_lane = wdata; end
            default: ;
        endcase
    end

    assign w_byte = rdata[8*r_bus_addr[1:0] +: 8];
    assign w_half = r_bus_addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        w_ext = 32'h0;
        case (r_op)
            OP_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_ext = {24'h0, w_byte};
            OP_LH:   w_ext = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_ext = {16'h0, w_half};
            OP_LW:   w_ext = rdata;
            default: w_ext = 32'h0;
        endcase
    end

    assign w_in_wait = (r_state == S_WAIT) || (r_state == S_DRAIN);
    assign w_wd_exp  = w_in_wait && (&r_wdog) && !data_ok;
    assign w_capture = !flush && data_ok && (((r_state == S_REQ) && addr_ok) || (r_state == S_WAIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Data arriving together with a flush is simply dropped rather than drained again.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_next = S_REQ;
            S_REQ: begin
                if (flush)        w_next = (addr_ok && !data_ok) ? S_DRAIN : S_IDLE;
                else if (addr_ok) w_next = data_ok ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (data_ok)       w_next = flush ? S_IDLE : S_DONE;
                else if (w_wd_exp) w_next = S_IDLE;
                else if (flush)    w_next = S_DRAIN;
            end
            S_DRAIN: if (data_ok || w_wd_exp) w_next = S_IDLE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req       = (r_state == S_REQ);
        done      = (r_state == S_DONE);
        mem_stall = w_launch || (r_state == S_REQ) || w_in_wait;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op        <= 8'h0;
            r_wr        <= 1'b0;
            r_size      <= 2'd0;
            r_bus_addr  <= 32'h0;
            r_wstrb     <= 4'h0;
            r_bus_wdata <= 32'h0;
            r_result    <= 32'h0;
            r_bus_err   <= 1'b0;
            r_wdog      <= '0;
        end else begin
            if (w_launch) begin
                r_op        <= op;
                r_wr        <= w_is_store;
                r_size      <= w_size;
                r_bus_addr  <= w_addr_al;
                r_wstrb     <= w_wstrb;
                r_bus_wdata <= w_lane;
            end
            if (w_capture) r_result <= r_wr ? 32'h0 : w_ext;
            r_bus_err <= w_wd_exp;
            // Counts consecutive cycles across WAIT and DRAIN; restarts on any other entry.
            if ((w_next == S_WAIT) || (w_next == S_DRAIN))
                r_wdog <= w_in_wait ? r_wdog + 1'b1 : '0;
            else
                r_wdog <= '0;
        end
    end

    assign wr        = r_wr;
    assign size      = r_size;
    assign bus_addr  = r_bus_addr;
    assign wstrb     = r_wstrb;
    assign bus_wdata = r_bus_wdata;
    assign result    = r_result;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, hand-written corner sequences, random vs reference model.
module tb_mem_access_unit;

    localparam logic [7:0] LB  = 8'b1110_0000;
    localparam logic [7:0] LH  = 8'b1110_0001;
    localparam logic [7:0] LW  = 8'b1110_0011;
    localparam logic [7:0] LBU = 8'b1110_0100;
    localparam logic [7:0] LHU = 8'b1110_0101;
    localparam logic [7:0] SB  = 8'b1110_1000;
    localparam logic [7:0] SH  = 8'b1110_1001;
    localparam logic [7:0] SW  = 8'b1110_1011;

    logic        clk, rst, in_valid, flush, addr_ok, data_ok;
    logic [7:0]  op;
    logic [31:0] addr, wdata, rdata;
    logic        req, wr, done, mem_stall, adel, ades, bus_err;
    logic [1:0]  size;
    logic [31:0] bus_addr, bus_wdata, result;
    logic [3:0]  wstrb;

    mem_access_unit #(.TIMEOUT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .addr(addr), .wdata(wdata),
        .flush(flush), .req(req), .wr(wr), .size(size), .bus_addr(bus_addr), .wstrb(wstrb),
        .bus_wdata(bus_wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .result(result), .done(done), .mem_stall(mem_stall), .adel(adel), .ades(ades),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        launch;
        logic [31:0] bus_addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] bus_wdata;
        logic        wr;
        logic [31:0] result;
        logic        adel;
        logic        ades;
    } exp_t;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr, wdata, rdata;
        int          aok, dok, stall;
        exp_t        e;
    } vec_t;

    typedef struct {
        int          stall_n, done_n;
        logic        req_seen, adel, ades, wr;
        logic [31:0] result, res_end, bus_addr, bus_wdata;
        logic [1:0]  size;
        logic [3:0]  wstrb;
    } obs_t;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] last_res = 32'h0;
    obs_t        o;
    vec_t        tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Reference: access width from the opcode, address rounded down, lanes by byte offset.
    function automatic exp_t model(input logic [7:0] o_, input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] rd);
        exp_t e;
        int nb, off;
        logic ld, sgn;
        logic [31:0] ea, mask, v, lane;
        e.launch = 0; e.bus_addr = 0; e.size = 0; e.wstrb = 0; e.bus_wdata = 0;
        e.wr = 0; e.result = 0; e.adel = 0; e.ades = 0;
        nb = 0; ld = 0; sgn = 0;
        case (o_)
            LB:  begin nb = 1; ld = 1; sgn = 1; end
            LBU: begin nb = 1; ld = 1; end
            LH:  begin nb = 2; ld = 1; sgn = 1; end
            LHU: begin nb = 2; ld = 1; end
            LW:  begin nb = 4; ld = 1; end
            SB:  nb = 1;
            SH:  nb = 2;
            SW:  nb = 4;
            default: nb = 0;
        endcase
        if (nb == 0) return e;
`ifdef MEM_ADDR_EXC_EN
        if ((a % nb) != 0) begin
            e.adel = ld;
            e.ades = !ld;
            return e;
        end
`endif
        ea   = a - (a % nb);
        off  = int'(ea % 4);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        e.launch   = 1;
        e.bus_addr = ea;
        e.size     = (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2;
        e.wr       = !ld;
        if (ld) begin
            v = (rd >> (8 * off)) & mask;
            if (sgn && v[8 * nb - 1]) v = v | ~mask;
            e.result = v;
        end else begin
            lane = wd & mask;
            for (int i = 0; i < 4; i += nb) e.bus_wdata = e.bus_wdata | (lane << (8 * i));
            e.wstrb = 4'(((1 << nb) - 1) << off);
        end
        return e;
    endfunction

    task automatic addv(input logic [7:0] t_op, input logic [31:0] t_addr, input logic [31:0] t_wd,
                        input logic [31:0] t_rd, input int aok, input int dok, input int stall,
                        input logic launch, input logic [31:0] res, input logic [31:0] baddr,
                        input logic [1:0] sz, input logic [3:0] strb, input logic [31:0] bwd,
                        input logic t_wr, input logic t_adel, input logic t_ades);
        vec_t v;
        v.op = t_op; v.addr = t_addr; v.wdata = t_wd; v.rdata = t_rd;
        v.aok = aok; v.dok = dok; v.stall = stall;
        v.e.launch = launch; v.e.result = res; v.e.bus_addr = baddr; v.e.size = sz;
        v.e.wstrb = strb; v.e.bus_wdata = bwd; v.e.wr = t_wr; v.e.adel = t_adel; v.e.ades = t_ades;
        tbl.push_back(v);
    endtask

    // Drives one instruction and plays the bus slave: addr_ok after aok REQ cycles, data_ok dok cycles later.
    task automatic run_txn(input logic [7:0] t_op, input logic [31:0] t_addr, input logic [31:0] t_wd,
                           input logic [31:0] t_rd, input int aok, input int dok);
        int acc;
        o.stall_n = 0; o.done_n = 0; o.req_seen = 0; o.result = 0; o.bus_addr = 0;
        o.bus_wdata = 0; o.size = 0; o.wstrb = 0; o.wr = 0;
        @(negedge clk);
        in_valid = 1'b1; op = t_op; addr = t_addr; wdata = t_wd;
        #1;
        if (mem_stall) o.stall_n++;
        @(negedge clk);
        in_valid = 1'b0; op = 8'h0; addr = 32'h0; wdata = 32'h0;
        o.adel = adel; o.ades = ades;
        acc = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            addr_ok = req && (acc < 0) && (cyc >= aok);
            if (addr_ok) begin
                acc = cyc;
                o.bus_addr = bus_addr; o.size = size; o.wstrb = wstrb;
                o.bus_wdata = bus_wdata; o.wr = wr;
            end
            data_ok = (acc >= 0) && (cyc == acc + dok);
            rdata   = data_ok ? t_rd : $urandom;
            #1;
            if (mem_stall) o.stall_n++;
            if (req) o.req_seen = 1'b1;
            if (done) begin
                o.done_n++;
                o.result = result;
            end else if (o.done_n > 0) break;
            @(negedge clk);
        end
        addr_ok = 1'b0; data_ok = 1'b0;
        o.res_end = result;
    endtask

    task automatic check_txn(input string tag, input exp_t e, input int exp_stall);
        chk({tag, "_stall"}, o.stall_n, exp_stall);
        chk({tag, "_req"}, {31'h0, o.req_seen}, {31'h0, e.launch});
        chk({tag, "_done"}, o.done_n, e.launch ? 1 : 0);
        chk({tag, "_adel"}, {31'h0, o.adel}, {31'h0, e.adel});
        chk({tag, "_ades"}, {31'h0, o.ades}, {31'h0, e.ades});
        if (e.launch) begin
            chk({tag, "_baddr"}, o.bus_addr, e.bus_addr);
            chk({tag, "_size"}, {30'h0, o.size}, {30'h0, e.size});
            chk({tag, "_wr"}, {31'h0, o.wr}, {31'h0, e.wr});
            chk({tag, "_result"}, o.result, e.result);
            if (e.wr) begin
                chk({tag, "_wstrb"}, {28'h0, o.wstrb}, {28'h0, e.wstrb});
                chk({tag, "_wdata"}, o.bus_wdata, e.bus_wdata);
            end
            last_res = e.result;
        end else begin
            chk({tag, "_held"}, o.res_end, last_res);
        end
    endtask

    task automatic launch_lw(input logic [31:0] a);
        @(negedge clk);
        in_valid = 1'b1; op = LW; addr = a; wdata = 32'h0;
        @(negedge clk);
        in_valid = 1'b0; op = 8'h0; addr = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int wcnt;
        logic berr, dseen;
        vec_t v;
        exp_t e;
        logic [7:0] ops[9];
        ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW, 8'h21};

        rst = 1'b0; in_valid = 1'b0; op = 8'h0; addr = 32'h0; wdata = 32'h0;
        flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", {31'h0, req}, 32'h0);
        chk("rst_stall", {31'h0, mem_stall}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_buses", {bus_addr ^ bus_wdata, 32'h0} != 64'h0 ? 32'h1 : {28'h0, wstrb} | {30'h0, size}, 32'h0);
        chk("rst_flags", {28'h0, wr, adel, ades, bus_err}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        addv(LW,  32'h100, 32'h0,       32'h8000_00FF, 0, 2, 4, 1, 32'h8000_00FF, 32'h100, 2'd2, 4'h0, 32'h0, 0, 0, 0);
        addv(LB,  32'h103, 32'h0,       32'h80AB_CDEF, 1, 1, 4, 1, 32'hFFFF_FF80, 32'h103, 2'd0, 4'h0, 32'h0, 0, 0, 0);
        addv(LBU, 32'h103, 32'h0,       32'h80AB_CDEF, 0, 0, 2, 1, 32'h0000_0080, 32'h103, 2'd0, 4'h0, 32'h0, 0, 0, 0);
        addv(SH,  32'h202, 32'h1234_ABCD, 32'h0,       0, 1, 3, 1, 32'h0, 32'h202, 2'd1, 4'b1100, 32'hABCD_ABCD, 1, 0, 0);
`ifdef MEM_ADDR_EXC_EN
        addv(LW,  32'h101, 32'h0,       32'h1122_3344, 0, 1, 0, 0, 32'h0, 32'h0, 2'd0, 4'h0, 32'h0, 0, 1, 0);
`else
        addv(LW,  32'h101, 32'h0,       32'h1122_3344, 0, 1, 3, 1, 32'h1122_3344, 32'h100, 2'd2, 4'h0, 32'h0, 0, 0, 0);
`endif
        addv(SB,  32'h101, 32'h3333_335A, 32'h0,       2, 0, 4, 1, 32'h0, 32'h101, 2'd0, 4'b0010, 32'h5A5A_5A5A, 1, 0, 0);
        addv(SW,  32'h300, 32'hCAFE_F00D, 32'h0,       0, 0, 2, 1, 32'h0, 32'h300, 2'd2, 4'b1111, 32'hCAFE_F00D, 1, 0, 0);
        addv(LH,  32'h106, 32'h0,       32'h8001_7FFF, 0, 1, 3, 1, 32'hFFFF_8001, 32'h106, 2'd1, 4'h0, 32'h0, 0, 0, 0);
        addv(8'h21, 32'h400, 32'h5555_5555, 32'h0,     0, 0, 0, 0, 32'h0, 32'h0, 2'd0, 4'h0, 32'h0, 0, 0, 0);
        addv(LHU, 32'h104, 32'h0,       32'h8001_FFFE, 1, 0, 3, 1, 32'h0000_FFFE, 32'h104, 2'd1, 4'h0, 32'h0, 0, 0, 0);
`ifdef MEM_ADDR_EXC_EN
        addv(SH,  32'h301, 32'h0000_BEEF, 32'h0,       0, 0, 0, 0, 32'h0, 32'h0, 2'd0, 4'h0, 32'h0, 0, 0, 1);
`else
        addv(SH,  32'h301, 32'h0000_BEEF, 32'h0,       0, 0, 2, 1, 32'h0, 32'h300, 2'd1, 4'b0011, 32'hBEEF_BEEF, 1, 0, 0);
`endif

        foreach (tbl[i]) begin
            v = tbl[i];
            run_txn(v.op, v.addr, v.wdata, v.rdata, v.aok, v.dok);
            check_txn($sformatf("vec%0d", i), v.e, v.stall);
        end

        // Flush in IDLE blocks the launch.
        @(negedge clk);
        in_valid = 1'b1; op = LW; addr = 32'h10; flush = 1'b1;
        #1 chk("fidle_stall", {31'h0, mem_stall}, 32'h0);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        #1 chk("fidle_req", {31'h0, req}, 32'h0);

        // Flush in REQ before addr_ok: back to IDLE, no done.
        launch_lw(32'h20);
        flush = 1'b1;
        #1 chk("freq_req", {31'h0, req}, 32'h1);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("freq_idle", {30'h0, req, mem_stall}, 32'h0);
        dseen = 1'b0;
        repeat (3) begin @(negedge clk); #1 if (done) dseen = 1'b1; end
        chk("freq_nodone", {31'h0, dseen}, 32'h0);

        // Flush in WAIT, data_ok two cycles later, then a clean LW.
        launch_lw(32'h40);
        addr_ok = 1'b1;
        @(negedge clk);
        addr_ok = 1'b0; flush = 1'b1;
        #1 chk("fwait_stall", {31'h0, mem_stall}, 32'h1);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("fdrain_stall", {31'h0, mem_stall}, 32'h1);
        @(negedge clk);
        data_ok = 1'b1; rdata = 32'h7777_7777;
        #1 chk("fdrain_done", {31'h0, done}, 32'h0);
        @(negedge clk);
        data_ok = 1'b0;
        #1 chk("fwait_idle", {30'h0, done, mem_stall}, 32'h0);
        chk("fwait_held", result, last_res);
        run_txn(LW, 32'h44, 32'h0, 32'h0BAD_F00D, 1, 2);
        check_txn("fwait_next", model(LW, 32'h44, 32'h0, 32'h0BAD_F00D), 5);

        // Reset while in WAIT: everything clears at once; a late data_ok is ignored.
        launch_lw(32'h80);
        addr_ok = 1'b1;
        @(negedge clk);
        addr_ok = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rstw_ctl", {26'h0, req, wr, done, mem_stall, bus_err, adel | ades}, 32'h0);
        chk("rstw_size_strb", {26'h0, size, wstrb}, 32'h0);
        chk("rstw_baddr", bus_addr, 32'h0);
        chk("rstw_bwdata", bus_wdata, 32'h0);
        chk("rstw_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        data_ok = 1'b1; rdata = 32'h1234_5678;
        @(negedge clk);
        data_ok = 1'b0;
        dseen = 1'b0;
        repeat (3) begin #1 if (done || mem_stall) dseen = 1'b1; @(negedge clk); end
        chk("rstw_ignored", {31'h0, dseen}, 32'h0);
        chk("rstw_result_after", result, 32'h0);
        last_res = 32'h0;

        // Randomised transactions against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [7:0]  r_op_v;
            logic [31:0] ra, rw, rr;
            int a_d, d_d;
            r_op_v = ops[$urandom_range(0, 8)];
            ra  = $urandom & 32'h0000_0FFF;
            rw  = $urandom;
            rr  = $urandom;
            a_d = $urandom_range(0, 3);
            d_d = $urandom_range(0, 3);
            e = model(r_op_v, ra, rw, rr);
            run_txn(r_op_v, ra, rw, rr, a_d, d_d);
            check_txn($sformatf("rnd%0d", i), e, e.launch ? 2 + a_d + d_d : 0);
        end

        // Watchdog: accepted read whose data never comes back.
        launch_lw(32'hC0);
        addr_ok = 1'b1;
        @(negedge clk);
        addr_ok = 1'b0;
        wcnt = 0; berr = 1'b0; dseen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (bus_err) begin berr = 1'b1; break; end
            if (mem_stall) wcnt++;
            if (done) dseen = 1'b1;
            @(negedge clk);
        end
        chk("wd_fired", {31'h0, berr}, 32'h1);
        chk("wd_cycles_ok", {31'h0, (wcnt == 255) || (wcnt == 256)}, 32'h1);
        chk("wd_idle", {30'h0, mem_stall, dseen}, 32'h0);
        @(negedge clk);
        #1 chk("wd_pulse", {31'h0, bus_err}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
